// File: rtl/ram_sp_if.sv
// Request/response bundle for the parametrised single-port RAM.
// The master drives requests and the slave returns read data and status.
interface ram_sp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] add;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              busy;
  logic              err;

  modport master (
    output wr, rd, add, din,
    input  dout, dout_valid, busy, err
  );

  modport slave (
    input  wr, rd, add, din,
    output dout, dout_valid, busy, err
  );
endinterface

// File: rtl/ram_sp_param.sv
// Parametrised single-port RAM with a registered read, a valid strobe,
// a range check and a post-reset clear sequencer.
module ram_sp_param #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int DEPTH        = 16,
  parameter int RD_MODE      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic   clk,
  input  logic   rst,
  ram_sp_if.slave bus
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;
  localparam logic [0:0] ST_RST   =
    (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              err_q, err_d;

  logic              in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign in_range = {1'b0, bus.add} < DEPTH_L;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    err_d        = 1'b0;
    mem_we       = 1'b0;
    mem_wa       = bus.add;
    mem_wd       = bus.din;
    unique case (1'b1)
      (state_q == ST_CLEAR): begin
        mem_we    = 1'b1;
        mem_wa    = clr_cnt_q;
        mem_wd    = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        err_d     = bus.wr | bus.rd;
        if (clr_cnt_q == LAST) begin
          state_d = ST_IDLE;
        end
      end
      (state_q == ST_IDLE): begin
        err_d  = (bus.wr | bus.rd) & ~in_range;
        mem_we = bus.wr & in_range;
        if (bus.rd) begin
          dout_valid_d = 1'b1;
          if (!in_range) begin
            dout_d = '0;
          end else if (RD_MODE != 0 && bus.wr) begin
            dout_d = bus.din;
          end else begin
            dout_d = mem[bus.add];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RST;
      clr_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      err_q        <= err_d;
    end
  end

  // Array has no reset; rst only blocks writes so reset dominates.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_sp_param.sv
// Scoreboard bench: four RAM configurations share one clock and reset.
// Stimulus pushes expected read/err events; a negedge monitor pops them.
module tb_ram_sp_param;

  typedef struct {
    bit          vld;
    bit          err;
    logic [31:0] data;
  } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        wr_t  [4];
  logic        rd_t  [4];
  logic [7:0]  add_t [4];
  logic [31:0] din_t [4];

  logic        vld_o  [4];
  logic        err_o  [4];
  logic        busy_o [4];
  logic [31:0] dat_o  [4];

  evt_t exp_q [4][$];
  int   fall  [4];

  ram_sp_if #(.DATA_W(8),  .ADDR_W(4)) if0 ();
  ram_sp_if #(.DATA_W(8),  .ADDR_W(4)) if1 ();
  ram_sp_if #(.DATA_W(8),  .ADDR_W(4)) if2 ();
  ram_sp_if #(.DATA_W(32), .ADDR_W(6)) if3 ();

  ram_sp_param #(.RD_MODE(0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  ram_sp_param #(.RD_MODE(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  ram_sp_param #(.DEPTH(12))  u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  ram_sp_param #(.DATA_W(32), .ADDR_W(6), .DEPTH(64))
    u3 (.clk(clk), .rst(rst), .bus(if3.slave));

  assign if0.wr = wr_t[0];
  assign if0.rd = rd_t[0];
  assign if0.add = add_t[0][3:0];
  assign if0.din = din_t[0][7:0];
  assign if1.wr = wr_t[1];
  assign if1.rd = rd_t[1];
  assign if1.add = add_t[1][3:0];
  assign if1.din = din_t[1][7:0];
  assign if2.wr = wr_t[2];
  assign if2.rd = rd_t[2];
  assign if2.add = add_t[2][3:0];
  assign if2.din = din_t[2][7:0];
  assign if3.wr = wr_t[3];
  assign if3.rd = rd_t[3];
  assign if3.add = add_t[3][5:0];
  assign if3.din = din_t[3];

  assign vld_o[0] = if0.dout_valid;
  assign vld_o[1] = if1.dout_valid;
  assign vld_o[2] = if2.dout_valid;
  assign vld_o[3] = if3.dout_valid;
  assign err_o[0] = if0.err;
  assign err_o[1] = if1.err;
  assign err_o[2] = if2.err;
  assign err_o[3] = if3.err;
  assign busy_o[0] = if0.busy;
  assign busy_o[1] = if1.busy;
  assign busy_o[2] = if2.busy;
  assign busy_o[3] = if3.busy;
  assign dat_o[0] = {24'h0, if0.dout};
  assign dat_o[1] = {24'h0, if1.dout};
  assign dat_o[2] = {24'h0, if2.dout};
  assign dat_o[3] = if3.dout;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (vld_o[k] === 1'b1 || err_o[k] === 1'b1) begin
        if (exp_q[k].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_evt dut%0d: vld=%b err=%b dout=%h",
                   k, vld_o[k], err_o[k], dat_o[k]);
        end else begin
          evt_t e;
          e = exp_q[k].pop_front();
          tests++;
          if (vld_o[k] !== e.vld || err_o[k] !== e.err ||
              (e.vld && dat_o[k] !== e.data)) begin
            fails++;
            $display("FAIL evt dut%0d: vld=%b err=%b dout=%h expected %b %b %h",
                     k, vld_o[k], err_o[k], dat_o[k], e.vld, e.err, e.data);
          end
        end
      end
    end
  end

  task automatic expect_ev(int k, bit v, bit e, logic [31:0] d);
    evt_t x;
    x.vld = v;
    x.err = e;
    x.data = d;
    exp_q[k].push_back(x);
  endtask

  // Called #1 after a rising edge; holds the request for one edge.
  task automatic req(int k, bit w, bit r, int a, logic [31:0] d);
    wr_t[k]  = w;
    rd_t[k]  = r;
    add_t[k] = 8'(a);
    din_t[k] = d;
    @(posedge clk);
    #1;
    wr_t[k] = 1'b0;
    rd_t[k] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic measure_clear(bit inject);
    for (int k = 0; k < 4; k++) fall[k] = 0;
    for (int n = 1; n <= 70; n++) begin
      @(posedge clk);
      #1;
      wr_t[0] = 1'b0;
      for (int k = 0; k < 4; k++)
        if (busy_o[k] === 1'b0 && fall[k] == 0) fall[k] = n;
      if (inject && n == 2) begin
        wr_t[0] = 1'b1;
        add_t[0] = 8'd3;
        din_t[0] = 32'h77;
        expect_ev(0, 1'b0, 1'b1, 32'h0);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      wr_t[k] = 1'b0;
      rd_t[k] = 1'b0;
      add_t[k] = 8'h0;
      din_t[k] = 32'h0;
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_dout%0d", k), dat_o[k], 32'h0);
      chk($sformatf("rst_vld%0d", k), 32'(vld_o[k]), 32'h0);
      chk($sformatf("rst_err%0d", k), 32'(err_o[k]), 32'h0);
      chk($sformatf("rst_busy%0d", k), 32'(busy_o[k]), 32'h1);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Clear length per depth, with a write dropped during clear.
    measure_clear(1'b1);
    chk("clear_len0", 32'(fall[0]), 32'd16);
    chk("clear_len1", 32'(fall[1]), 32'd16);
    chk("clear_len2", 32'(fall[2]), 32'd12);
    chk("clear_len3", 32'(fall[3]), 32'd64);

    for (int i = 0; i < 16; i++) begin
      expect_ev(0, 1'b1, 1'b0, 32'h0);
      req(0, 1'b0, 1'b1, i, 32'h0);
    end

    for (int i = 0; i < 16; i++) begin
      req(0, 1'b1, 1'b0, i, 32'(i));
      expect_ev(0, 1'b1, 1'b0, 32'(i));
      req(0, 1'b0, 1'b1, i, 32'h0);
    end
    idle(3);
    chk("hold_dout", dat_o[0], 32'h0F);
    chk("hold_vld", 32'(vld_o[0]), 32'h0);

    req(0, 1'b1, 1'b0, 5, 32'hAA);
    req(1, 1'b1, 1'b0, 5, 32'hAA);
    expect_ev(0, 1'b1, 1'b0, 32'hAA);
    req(0, 1'b1, 1'b1, 5, 32'h55);
    expect_ev(1, 1'b1, 1'b0, 32'h55);
    req(1, 1'b1, 1'b1, 5, 32'h55);
    expect_ev(0, 1'b1, 1'b0, 32'h55);
    req(0, 1'b0, 1'b1, 5, 32'h0);
    expect_ev(1, 1'b1, 1'b0, 32'h55);
    req(1, 1'b0, 1'b1, 5, 32'h0);

    for (int i = 0; i < 12; i++) req(2, 1'b1, 1'b0, i, 32'(i + 16));
    expect_ev(2, 1'b0, 1'b1, 32'h0);
    req(2, 1'b1, 1'b0, 13, 32'hFF);
    idle(1);
    expect_ev(2, 1'b1, 1'b1, 32'h0);
    req(2, 1'b0, 1'b1, 13, 32'h0);
    idle(1);
    chk("oor_dout", dat_o[2], 32'h0);
    for (int i = 0; i < 12; i++) begin
      expect_ev(2, 1'b1, 1'b0, 32'(i + 16));
      req(2, 1'b0, 1'b1, i, 32'h0);
    end

    req(3, 1'b1, 1'b0, 63, 32'hDEADBEEF);
    expect_ev(3, 1'b1, 1'b0, 32'hDEADBEEF);
    req(3, 1'b0, 1'b1, 63, 32'h0);
    idle(3);

    // Reset from idle with dout holding 8'h55.
    chk("pre_rst_dout", dat_o[0], 32'h55);
    rst = 1'b1;
    #1;
    chk("mid_op_rst_dout", dat_o[0], 32'h0);
    chk("mid_op_rst_busy", 32'(busy_o[0]), 32'h1);
    idle(2);
    rst = 1'b0;

    // Run clear to clr_cnt=7 with a dropped read pending, then reset.
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk);
      #1;
      rd_t[0] = (n == 6);
    end
    chk("pre_rst_err", 32'(err_o[0]), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_clr_err", 32'(err_o[0]), 32'h0);
    chk("mid_clr_vld", 32'(vld_o[0]), 32'h0);
    chk("mid_clr_dout", dat_o[0], 32'h0);
    idle(2);
    rst = 1'b0;
    measure_clear(1'b0);
    chk("reclear_len0", 32'(fall[0]), 32'd16);

    expect_ev(0, 1'b1, 1'b0, 32'h0);
    req(0, 1'b0, 1'b1, 3, 32'h0);
    idle(3);
    for (int k = 0; k < 4; k++)
      chk($sformatf("drain%0d", k), 32'(exp_q[k].size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_sp_param.md
Name: ram_sp_param

Overview:
- Parametrised single-port synchronous RAM. Successor to the fixed 16x8 RAM.
- Generalised in data width, address width and depth.
- Adds a registered read with a valid strobe, a selectable read-during-write mode, and out-of-range address detection.
- Adds a post-reset clear sequencer, so that memory contents are defined after reset.
- Used as the generic storage primitive for buffers and register files in the datapath.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- ADDR_W, 4, address width in bits (>=1).
- DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_W.
- RD_MODE, 0, behaviour of a read to the address written in the same cycle: 0 = read-first (old data), 1 = write-first (new data).
- CLEAR_ON_RST, 1, 1 = zero every word after reset via the sequencer; 0 = no clear, contents undefined after power-up.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr  in  1  write request, sampled at the rising clk edge.
- rd  in  1  read request, sampled at the rising clk edge.
- add  in  ADDR_W  word address for wr/rd.
- din  in  DATA_W  write data.
- dout  out  DATA_W  registered read data.
- dout_valid  out  1  one-cycle strobe: dout was updated by a read this cycle.
- busy  out  1  clear sequencer active; wr/rd are not accepted.
- err  out  1  one-cycle strobe: the previous accepted request was out-of-range, or the request was dropped because busy=1.

Behaviour:
- Reset (rst=1, asynchronous):
  - dout=0, dout_valid=0, err=0.
  - State = CLEAR with clr_cnt=0 if CLEAR_ON_RST=1; otherwise state = IDLE.
  - busy=1 while rst is high and CLEAR_ON_RST=1; busy=0 otherwise.
  - The memory array itself is not asynchronously reset.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each rising edge writes 0 to mem[clr_cnt] and increments clr_cnt.
  - On the edge that writes mem[DEPTH-1], go to IDLE; busy deasserts after that edge.
  - Clear takes exactly DEPTH cycles after rst deasserts.
  - Any wr or rd sampled in CLEAR is dropped and gives err=1 on the next cycle. The memory and dout are untouched.
- IDLE, with a request sampled at edge N:
  - wr=1, add<DEPTH: mem[add] <= din.
  - rd=1, add<DEPTH: dout <= mem[add] after edge N, with dout_valid=1 for one cycle (read latency 1).
  - wr=1 and rd=1, same add:
    - RD_MODE=0: dout = the old contents.
    - RD_MODE=1: dout = din.
    - The write always completes.
  - add>=DEPTH (only possible when DEPTH<2**ADDR_W):
    - The write is ignored.
    - A read sets dout=0 and dout_valid=1.
    - err=1 for one cycle.
  - No rd: dout holds its last value and dout_valid=0.
- err and dout_valid are registered and are never asserted for more than one cycle per request.
- Reset asserted mid-clear or mid-operation:
  - Outputs return to their reset values immediately.
  - The clear restarts from address 0 after rst deasserts.
  - A write in flight on the same edge that reset asserts is not guaranteed.
- Reset dominates all other inputs.
- clr_cnt width is ADDR_W. No wrap-around is possible, because the terminal count is DEPTH-1.

Test Plan:
- Clear after reset (defaults): pulse rst for 2 cycles, hold wr=rd=0.
  - Required: busy=1 for exactly 16 cycles after rst falls, then 0.
  - Then read addresses 0..15: every dout=8'h00 with dout_valid=1.
- Write/read sweep (defaults): for i=0..15 write din=i to add=i, then read add=i.
  - Required: dout=i one cycle after each rd, dout_valid high for 1 cycle.
  - dout holds its value while rd=0.
- Read-during-write: mem[5]=8'hAA, then wr=rd=1, add=5, din=8'h55.
  - RD_MODE=0: dout=8'hAA.
  - RD_MODE=1: dout=8'h55.
  - A following read of add=5 gives 8'h55 in both modes.
- Out-of-range (DEPTH=12, ADDR_W=4): write 8'hFF to add=13, then read add=13.
  - Required: err=1 for one cycle after each request; dout=0.
  - mem[0..11] unchanged.
- Access while busy: issue wr add=3 din=8'h77 during CLEAR.
  - Required: err=1 next cycle.
  - After busy falls, a read of add=3 returns 8'h00.
- Reset mid-clear: assert rst when clr_cnt=7.
  - Required: dout=0, dout_valid=0, err=0 immediately.
  - After release, busy lasts a full 16 cycles again.
- Width scaling (DATA_W=32, ADDR_W=6, DEPTH=64): write 32'hDEADBEEF to add=63, then read it back.
  - Required: dout=32'hDEADBEEF.
